// File: rtl/comp_unpack.sv
// Splits packed 2*p_size words into two p_size halves through a p_depth FIFO.
// Outputs are registered; overflow drops the incoming word and sets a sticky flag.
module comp_unpack #(
  parameter int p_size  = 4,
  parameter int p_depth = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2*p_size-1:0]          i_param,
  input  logic                         i_dv,
  input  logic                         i_ack,
  input  logic                         i_clr,
  output logic [p_size-1:0]            o_param,
  output logic [p_size-1:0]            o_param_2,
  output logic                         o_ena,
  output logic [$clog2(p_depth):0]     o_level,
  output logic                         o_ovf
);

  localparam int AW = $clog2(p_depth);
  localparam int LW = AW + 1;
  localparam int DW = 2 * p_size;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ena_q, ena_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] mem_q [p_depth];

  logic full, pop, push, drop;

  always_comb begin
    full     = (level_q == LW'(p_depth));
    pop      = ena_q && i_ack;
    push     = i_dv && (!full || pop);
    drop     = i_dv && full && !pop;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    ena_d    = (level_d != '0);

    // New head is the word being written this cycle when the read pointer
    // lands on the write slot (FIFO empty, or last word popped while pushing).
    head_d   = head_q;
    if (ena_d) begin
      if (push && (rd_ptr_d == wr_ptr_q)) head_d = i_param;
      else                                head_d = mem_q[rd_ptr_d];
    end

    ovf_d    = drop | (ovf_q & ~i_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ena_q    <= 1'b0;
      ovf_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ena_q    <= ena_d;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_param;
  end

  assign o_param   = head_q[p_size-1:0];
  assign o_param_2 = head_q[DW-1:p_size];
  assign o_ena     = ena_q;
  assign o_level   = level_q;
  assign o_ovf     = ovf_q;

endmodule

// File: tb/tb_comp_unpack.sv
// Directed and random-with-scoreboard bench for comp_unpack (p_size=4, p_depth=4).
module tb_comp_unpack;

  logic       clk;
  logic       rst;
  logic [7:0] i_param;
  logic       i_dv;
  logic       i_ack;
  logic       i_clr;
  logic [3:0] o_param;
  logic [3:0] o_param_2;
  logic       o_ena;
  logic [2:0] o_level;
  logic       o_ovf;

  int checks;
  int failures;

  comp_unpack #(.p_size(4), .p_depth(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_param   (i_param),
    .i_dv      (i_dv),
    .i_ack     (i_ack),
    .i_clr     (i_clr),
    .o_param   (o_param),
    .o_param_2 (o_param_2),
    .o_ena     (o_ena),
    .o_level   (o_level),
    .o_ovf     (o_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    i_param = w;
    i_dv    = 1'b1;
    tick();
    i_dv    = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] w);
    chk(tag, {28'd0, o_ena}, 32'd1);
    chk(tag, {24'd0, o_param_2, o_param}, {24'd0, w});
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
  endtask

  logic [7:0] q[$];
  logic       m_ovf;
  logic       m_pop, m_push;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    i_param  = 8'h00;
    i_dv     = 1'b0;
    i_ack    = 1'b0;
    i_clr    = 1'b0;
    #2;
    chk("reset_ena",   {31'd0, o_ena}, 32'd0);
    chk("reset_level", {29'd0, o_level}, 32'd0);
    chk("reset_ovf",   {31'd0, o_ovf}, 32'd0);
    chk("reset_data",  {24'd0, o_param_2, o_param}, 32'd0);
    rst = 1'b1;
    tick();

    // Single word into empty FIFO
    push_word(8'hA5);
    chk("single_ena",   {31'd0, o_ena}, 32'd1);
    chk("single_lo",    {28'd0, o_param}, 32'h5);
    chk("single_hi",    {28'd0, o_param_2}, 32'hA);
    chk("single_level", {29'd0, o_level}, 32'd1);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    chk("single_pop_ena",   {31'd0, o_ena}, 32'd0);
    chk("single_pop_level", {29'd0, o_level}, 32'd0);

    // Fill, overflow, drain, clear
    for (int k = 1; k <= 4; k++) push_word(8'(k));
    chk("fill_level", {29'd0, o_level}, 32'd4);
    chk("fill_ovf",   {31'd0, o_ovf}, 32'd0);
    push_word(8'h05);
    chk("ovf_set",    {31'd0, o_ovf}, 32'd1);
    chk("ovf_level",  {29'd0, o_level}, 32'd4);
    for (int k = 1; k <= 4; k++) pop_expect("fill_pop", 8'(k));
    chk("fill_empty",    {31'd0, o_ena}, 32'd0);
    chk("ovf_sticky",    {31'd0, o_ovf}, 32'd1);
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    chk("ovf_clr", {31'd0, o_ovf}, 32'd0);

    // Full with simultaneous push and pop
    for (int k = 1; k <= 4; k++) push_word(8'(k));
    i_param = 8'h99;
    i_dv    = 1'b1;
    i_ack   = 1'b1;
    tick();
    i_dv    = 1'b0;
    i_ack   = 1'b0;
    chk("fullpp_ovf",   {31'd0, o_ovf}, 32'd0);
    chk("fullpp_level", {29'd0, o_level}, 32'd4);
    pop_expect("fullpp_pop", 8'h02);
    pop_expect("fullpp_pop", 8'h03);
    pop_expect("fullpp_pop", 8'h04);
    pop_expect("fullpp_pop", 8'h99);
    chk("fullpp_empty", {31'd0, o_ena}, 32'd0);

    // Streaming: push and ack every cycle
    for (int k = 0; k < 20; k++) begin
      i_param = 8'(k);
      i_dv    = 1'b1;
      i_ack   = 1'b1;
      tick();
      chk("stream_data",  {24'd0, o_param_2, o_param}, 32'(k));
      chk("stream_level", {31'd0, (o_level <= 3'd1)}, 32'd1);
    end
    i_dv = 1'b0;
    tick();
    i_ack = 1'b0;
    chk("stream_drained", {29'd0, o_level}, 32'd0);

    // Asynchronous reset mid-stream with three words queued
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    chk("pre_rst_level", {29'd0, o_level}, 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_ena",   {31'd0, o_ena}, 32'd0);
    chk("async_rst_level", {29'd0, o_level}, 32'd0);
    chk("async_rst_ovf",   {31'd0, o_ovf}, 32'd0);
    rst = 1'b1;
    tick();
    push_word(8'h44);
    chk("post_rst_level", {29'd0, o_level}, 32'd1);
    pop_expect("post_rst_pop", 8'h44);
    chk("post_rst_empty", {31'd0, o_ena}, 32'd0);

    // Random stall/wrap against a queue scoreboard
    q.delete();
    m_ovf = 1'b0;
    for (int c = 0; c < 200; c++) begin
      i_param = 8'($urandom_range(0, 255));
      i_dv    = ($urandom_range(0, 9) < 6);
      i_ack   = ($urandom_range(0, 9) < 4);
      i_clr   = ($urandom_range(0, 19) == 0);
      m_pop   = (q.size() != 0) && i_ack;
      m_push  = i_dv && ((q.size() < 4) || m_pop);
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(i_param);
      if (i_dv && !m_push) m_ovf = 1'b1;
      else if (i_clr)      m_ovf = 1'b0;
      tick();
      chk("rand_ena",   {31'd0, o_ena}, {31'd0, (q.size() != 0)});
      chk("rand_level", {29'd0, o_level}, 32'(q.size()));
      chk("rand_ovf",   {31'd0, o_ovf}, {31'd0, m_ovf});
      if (q.size() != 0) chk("rand_head", {24'd0, o_param_2, o_param}, {24'd0, q[0]});
    end
    i_dv  = 1'b0;
    i_ack = 1'b0;
    i_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
